// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module : aes_pkg
// Brief  : AES-128 S-boxes, round functions, key expansion and FSM state type.
// Rev    : 1.0
// ============================================================================
package aes_pkg;

   localparam int NR   = 10;
   localparam int KS_W = 128 * (NR + 1);

   typedef enum logic [1:0] {IDLE, ROUND, DONE} aes_state_e;

   localparam logic [7:0] c_sbox [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};

   localparam logic [7:0] c_inv_sbox [256] = '{
      8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
      8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
      8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
      8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
      8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
      8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
      8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
      8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
      8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
      8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
      8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
      8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
      8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
      8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
      8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
      8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d};

   function automatic logic [7:0] fn_xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] fn_gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p  = 8'h00;
      logic [7:0] aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = fn_xtime(aa);
      end
      return p;
   endfunction

   // Byte k of the state is row k%4, column k/4; bit 0 is the MSB of byte 0.
   function automatic logic [0:127] fn_inv_shift_rows(input logic [0:127] s);
      logic [0:127] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[8*(4*c+r) +: 8] = s[8*(4*((c - r + 4) % 4) + r) +: 8];
      return o;
   endfunction

   function automatic logic [0:127] fn_shift_rows(input logic [0:127] s);
      logic [0:127] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[8*(4*c+r) +: 8] = s[8*(4*((c + r) % 4) + r) +: 8];
      return o;
   endfunction

   function automatic logic [0:127] fn_inv_sub_bytes(input logic [0:127] s);
      logic [0:127] o;
      for (int k = 0; k < 16; k++) o[8*k +: 8] = c_inv_sbox[s[8*k +: 8]];
      return o;
   endfunction

   function automatic logic [0:127] fn_sub_bytes(input logic [0:127] s);
      logic [0:127] o;
      for (int k = 0; k < 16; k++) o[8*k +: 8] = c_sbox[s[8*k +: 8]];
      return o;
   endfunction

   function automatic logic [0:127] fn_inv_mix_columns(input logic [0:127] s);
      logic [0:127] o;
      logic [7:0]   a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[32*c +: 8];      a1 = s[32*c+8 +: 8];
         a2 = s[32*c+16 +: 8];   a3 = s[32*c+24 +: 8];
         o[32*c    +: 8] = fn_gf_mul(a0,8'h0e) ^ fn_gf_mul(a1,8'h0b) ^ fn_gf_mul(a2,8'h0d) ^ fn_gf_mul(a3,8'h09);
         o[32*c+8  +: 8] = fn_gf_mul(a0,8'h09) ^ fn_gf_mul(a1,8'h0e) ^ fn_gf_mul(a2,8'h0b) ^ fn_gf_mul(a3,8'h0d);
         o[32*c+16 +: 8] = fn_gf_mul(a0,8'h0d) ^ fn_gf_mul(a1,8'h09) ^ fn_gf_mul(a2,8'h0e) ^ fn_gf_mul(a3,8'h0b);
         o[32*c+24 +: 8] = fn_gf_mul(a0,8'h0b) ^ fn_gf_mul(a1,8'h0d) ^ fn_gf_mul(a2,8'h09) ^ fn_gf_mul(a3,8'h0e);
      end
      return o;
   endfunction

   function automatic logic [0:127] fn_mix_columns(input logic [0:127] s);
      logic [0:127] o;
      logic [7:0]   a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[32*c +: 8];      a1 = s[32*c+8 +: 8];
         a2 = s[32*c+16 +: 8];   a3 = s[32*c+24 +: 8];
         o[32*c    +: 8] = fn_xtime(a0) ^ fn_xtime(a1) ^ a1 ^ a2 ^ a3;
         o[32*c+8  +: 8] = a0 ^ fn_xtime(a1) ^ fn_xtime(a2) ^ a2 ^ a3;
         o[32*c+16 +: 8] = a0 ^ a1 ^ fn_xtime(a2) ^ fn_xtime(a3) ^ a3;
         o[32*c+24 +: 8] = fn_xtime(a0) ^ a0 ^ a1 ^ a2 ^ fn_xtime(a3);
      end
      return o;
   endfunction

   function automatic logic [0:127] fn_round_key(input logic [0:KS_W-1] ks, input logic [3:0] r);
      return ks[128*r +: 128];
   endfunction

   function automatic logic [0:KS_W-1] fn_key_expand(input logic [0:127] key);
      logic [0:KS_W-1] ks;
      logic [31:0]     t;
      logic [7:0]      rcon = 8'h01;
      ks[0:127] = key;
      for (int i = 4; i < 4 * (NR + 1); i++) begin
         t = ks[32*(i-1) +: 32];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            for (int j = 0; j < 4; j++) t[8*j +: 8] = c_sbox[t[8*j +: 8]];
            t[31:24] = t[31:24] ^ rcon;
            rcon     = fn_xtime(rcon);
         end
         ks[32*i +: 32] = ks[32*(i-4) +: 32] ^ t;
      end
      return ks;
   endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_round.sv
`default_nettype none
// ============================================================================
// Module : aes_inv_round
// Brief  : One combinational AES inverse round; last_round skips InvMixColumns.
// Rev    : 1.0
// ============================================================================
module aes_inv_round
   import aes_pkg::*;
(
   input  logic [0:127] i_state,
   input  logic [0:127] i_round_key,
   input  logic         i_last_round,
   output logic [0:127] o_next_state
);

   logic [0:127] w_pre_mix;

   assign w_pre_mix    = fn_inv_sub_bytes(fn_inv_shift_rows(i_state)) ^ i_round_key;
   assign o_next_state = i_last_round ? w_pre_mix : fn_inv_mix_columns(w_pre_mix);

endmodule
`default_nettype wire

// File: rtl/aes_decrypt_iterative.sv
`default_nettype none
// ============================================================================
// Module : aes_decrypt_iterative
// Brief  : Iterative AES-128 inverse cipher, one round per clock, valid/ready.
// Rev    : 1.0
// ============================================================================
module aes_decrypt_iterative #(
   parameter int NR   = 10,
   parameter int KS_W = 1408
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [0:127]    i_cipher_text,
   input  logic [0:KS_W-1] i_key_schedule,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [0:127]    o_plain_text,
   output logic            o_busy
);
   import aes_pkg::*;

   localparam logic [3:0] c_last_rk   = 4'(NR);
   localparam logic [3:0] c_first_cnt = 4'(NR - 1);

   aes_state_e       r_state;
   aes_state_e       w_next_state;
   logic [3:0]       r_cnt;
   logic [0:127]     r_data;
   logic [0:KS_W-1]  r_ks;
   logic [0:127]     w_round_key;
   logic [0:127]     w_round_out;
   logic             w_accept;
   logic             w_last;

   assign o_ready     = (r_state == IDLE) || ((r_state == DONE) && i_ready);
   assign o_busy      = (r_state == ROUND);
   assign w_accept    = i_valid && o_ready;
   assign w_last      = (r_cnt == 4'd0);
   assign w_round_key = fn_round_key(r_ks, r_cnt);

   aes_inv_round u_inv_round (
      .i_state      (r_data),
      .i_round_key  (w_round_key),
      .i_last_round (w_last),
      .o_next_state (w_round_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next_state = ROUND;
         ROUND:   if (w_last)   w_next_state = DONE;
         DONE: begin
            if (w_accept)     w_next_state = ROUND;
            else if (i_ready) w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   // A DONE-state accept both retires the output and loads the next block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt        <= 4'd0;
         r_data       <= '0;
         r_ks         <= '0;
         o_plain_text <= '0;
         o_valid      <= 1'b0;
      end else begin
         if (w_accept) begin
            r_ks   <= i_key_schedule;
            r_data <= i_cipher_text ^ fn_round_key(i_key_schedule, c_last_rk);
            r_cnt  <= c_first_cnt;
         end else if ((r_state == ROUND) && !w_last) begin
            r_data <= w_round_out;
            r_cnt  <= r_cnt - 4'd1;
         end

         if ((r_state == ROUND) && w_last) begin
            o_plain_text <= w_round_out;
            o_valid      <= 1'b1;
         end else if ((r_state == DONE) && i_ready) begin
            o_valid      <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_aes_decrypt_iterative.sv
`default_nettype none
// ============================================================================
// Module : tb_aes_decrypt_iterative
// Brief  : Directed-vector bench for the iterative AES-128 inverse cipher.
// Rev    : 1.0
// ============================================================================
module tb_aes_decrypt_iterative;
   import aes_pkg::*;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            i_valid = 1'b0;
   logic            o_ready;
   logic [0:127]    i_cipher_text = '0;
   logic [0:KS_W-1] i_key_schedule = '0;
   logic            o_valid;
   logic            i_ready = 1'b1;
   logic [0:127]    o_plain_text;
   logic            o_busy;

   int n_vec = 0;
   int n_err = 0;

   localparam logic [0:127] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [0:127] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [0:127] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [0:127] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [0:127] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [0:127] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   // The accepting edge is the load edge; o_valid is seen after the 10th
   // edge following it, i.e. the 11th edge counting the accepting one.
   localparam int LAT = 10;

   aes_decrypt_iterative #(.NR(10), .KS_W(1408)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_valid        (i_valid),
      .o_ready        (o_ready),
      .i_cipher_text  (i_cipher_text),
      .i_key_schedule (i_key_schedule),
      .o_valid        (o_valid),
      .i_ready        (i_ready),
      .o_plain_text   (o_plain_text),
      .o_busy         (o_busy)
   );

   always #5 clk = ~clk;

   function automatic logic [0:127] encrypt(input logic [0:127] pt, input logic [0:KS_W-1] ks);
      logic [0:127] s = pt ^ fn_round_key(ks, 4'd0);
      for (int r = 1; r < 10; r++)
         s = fn_mix_columns(fn_shift_rows(fn_sub_bytes(s))) ^ fn_round_key(ks, 4'(r));
      return fn_shift_rows(fn_sub_bytes(s)) ^ fn_round_key(ks, 4'd10);
   endfunction

   // Called and returns at posedge+1; ok=1 means accepted on the last edge.
   task automatic send(input logic [0:127] ct, input logic [0:KS_W-1] ks, output bit ok);
      i_cipher_text  = ct;
      i_key_schedule = ks;
      i_valid        = 1'b1;
      ok             = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         if (o_ready) ok = 1'b1;
         @(posedge clk); #1;
      end
      i_valid       = 1'b0;
      i_cipher_text = 128'hdeadbeef_0badf00d_cafebabe_01234567;
   endtask

   task automatic wait_valid(output int edges);
      edges = 0;
      while (!o_valid && edges < 30) begin
         @(posedge clk); #1;
         edges++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", o_valid); end
      n_vec++; if (o_plain_text !== '0) begin n_err++; $display("FAIL rst_pt: got %h want 0", o_plain_text); end
      n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", o_busy); end
      n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", o_ready); end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_vector(input string name, input logic [0:127] key,
                              input logic [0:127] ct, input logic [0:127] pt);
      bit ok;
      int edges;
      i_ready = 1'b1;
      send(ct, fn_key_expand(key), ok);
      n_vec++; if (o_busy !== 1'b1 || !ok) begin n_err++; $display("FAIL %s_busy: got busy=%b ok=%b want 1/1", name, o_busy, ok); end
      i_key_schedule = '1;
      wait_valid(edges);
      n_vec++; if (edges !== LAT) begin n_err++; $display("FAIL %s_latency: got %0d want %0d", name, edges, LAT); end
      n_vec++; if (o_plain_text !== pt) begin n_err++; $display("FAIL %s_pt: got %h want %h", name, o_plain_text, pt); end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      bit ok;
      int edges;
      int bad = 0;
      i_ready = 1'b0;
      send(C1_CT, fn_key_expand(C1_KEY), ok);
      wait_valid(edges);
      for (int i = 0; i < 20; i++) begin
         if (o_valid !== 1'b1 || o_plain_text !== C1_PT || o_ready !== 1'b0) bad++;
         @(posedge clk); #1;
      end
      n_vec++; if (bad != 0) begin n_err++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); end
      i_ready = 1'b1;
      #1;
      n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_done: got %b want 1", o_ready); end
      @(posedge clk); #1;
      n_vec++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
         n_err++; $display("FAIL bp_release: got valid=%b ready=%b want 0/1", o_valid, o_ready);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int edges;
      i_ready = 1'b0;
      send(B_CT, fn_key_expand(B_KEY), ok);
      wait_valid(edges);
      n_vec++; if (o_plain_text !== B_PT || edges !== LAT) begin
         n_err++; $display("FAIL b2b_a: got %h lat %0d want %h lat %0d", o_plain_text, edges, B_PT, LAT);
      end
      i_ready = 1'b1;
      send(C1_CT, fn_key_expand(C1_KEY), ok);
      n_vec++; if (!ok || o_valid !== 1'b0 || o_busy !== 1'b1) begin
         n_err++; $display("FAIL b2b_accept: got ok=%b valid=%b busy=%b want 1/0/1", ok, o_valid, o_busy);
      end
      wait_valid(edges);
      n_vec++; if (o_plain_text !== C1_PT || edges !== LAT) begin
         n_err++; $display("FAIL b2b_b: got %h lat %0d want %h lat %0d", o_plain_text, edges, C1_PT, LAT);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      bit ok;
      int edges;
      int spurious = 0;
      i_ready = 1'b1;
      send(C1_CT, fn_key_expand(C1_KEY), ok);
      repeat (4) begin @(posedge clk); #1; end
      n_vec++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL mid_busy: got %b want 1", o_busy); end
      #2 rst_n = 1'b0;
      #1;
      n_vec++; if (o_valid !== 1'b0 || o_plain_text !== '0 || o_busy !== 1'b0) begin
         n_err++; $display("FAIL mid_async: got valid=%b pt=%h busy=%b want 0/0/0", o_valid, o_plain_text, o_busy);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (15) begin
         if (o_valid !== 1'b0 || o_busy !== 1'b0) spurious++;
         @(posedge clk); #1;
      end
      n_vec++; if (spurious != 0) begin n_err++; $display("FAIL mid_discard: got %0d active cycles want 0", spurious); end
      send(C1_CT, fn_key_expand(C1_KEY), ok);
      wait_valid(edges);
      n_vec++; if (o_plain_text !== C1_PT || edges !== LAT) begin
         n_err++; $display("FAIL mid_fresh: got %h lat %0d want %h lat %0d", o_plain_text, edges, C1_PT, LAT);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_round_trip();
      bit              ok;
      int              edges;
      logic [0:127]    key, pt;
      logic [0:KS_W-1] ks;
      for (int n = 0; n < 100; n++) begin
         key = {$urandom, $urandom, $urandom, $urandom};
         pt  = {$urandom, $urandom, $urandom, $urandom};
         ks  = fn_key_expand(key);
         i_ready = 1'b0;
         send(encrypt(pt, ks), ks, ok);
         i_valid       = 1'b1;
         i_cipher_text = {$urandom, $urandom, $urandom, $urandom};
         n_vec++; if (o_ready !== 1'b0 || !ok) begin n_err++; $display("FAIL rt_holdoff[%0d]: got ready=%b ok=%b want 0/1", n, o_ready, ok); end
         wait_valid(edges);
         n_vec++; if (edges !== LAT) begin n_err++; $display("FAIL rt_latency[%0d]: got %0d want %0d", n, edges, LAT); end
         n_vec++; if (o_plain_text !== pt) begin n_err++; $display("FAIL rt_pt[%0d]: got %h want %h", n, o_plain_text, pt); end
         i_valid = 1'b0;
         i_ready = 1'b1;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_vector("c1", C1_KEY, C1_CT, C1_PT);
      test_vector("appb", B_KEY, B_CT, B_PT);
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_round_trip();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
